sobel_edge_packer: RTL
======================

Name: sobel_edge_packer

Overview:
- Downstream consumer of the Sobel core's binary edge stream (pixel_out is 0 or 255, qualified by pixel_valid_out).
- Packs 8 edge bits per byte, LSB-first, and pads each output row to a byte boundary.
- Buffers the packed bytes in a small FIFO and presents them on a valid/ready byte stream with an end-of-frame marker.
- Counts edge pixels per frame for status readout.

Parameters:
- OUT_W, 510, valid edge pixels per row delivered by the Sobel core (SIZE-2).
- OUT_H, 510, valid edge rows per frame (SIZE-2).
- FIFO_DEPTH, 16, packed-byte FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pixel_in  in  8  edge pixel from the Sobel core; only bit 7 is used.
- pixel_valid_in  in  1  pixel_in is valid this cycle. Cannot be stalled.
- out_data  out  8  packed byte; bit k = k-th pixel of the group.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte when out_valid && out_ready.
- out_last  out  1  out_data is the final byte of the frame.
- edge_count  out  32  number of edge pixels (bit = 1) in the last completed input frame.
- frame_done  out  1  one-cycle pulse when the out_last byte is accepted.
- overflow  out  1  sticky: a packed byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n = 0 at a clk edge): out_valid, out_last, out_data, frame_done, overflow, edge_count = 0. The FIFO is emptied. Pack register, bit_cnt, col, row and the running edge count = 0. Reset mid-frame discards the partial frame; the next valid pixel is treated as col 0, row 0.
- Per valid input pixel:
  - b = pixel_in[7].
  - pack_next = pack | (b << bit_cnt).
  - running count increments by b.
- Byte completion when bit_cnt == 7 OR col == OUT_W-1:
  - pack_next is pushed to the FIFO with last flag = (col == OUT_W-1 && row == OUT_H-1).
  - Then pack = 0, bit_cnt = 0. Otherwise bit_cnt increments.
  - Row-end padding bits are 0. Bytes per row = ceil(OUT_W/8); default 64 bytes/row, 32640 bytes/frame.
- Coordinates:
  - col wraps at OUT_W-1 and increments row.
  - row wraps at OUT_H-1 to 0.
  - On the frame's final pixel, edge_count <= running + b and running <= 0, in the same cycle.
- Idle cycles (pixel_valid_in = 0) change no pack or coordinate state.
- FIFO:
  - First-word-fall-through; out_data and out_last are driven from the head entry.
  - out_valid = (count != 0).
  - Latency: a byte pushed at edge N is visible on out_valid/out_data after edge N, i.e. 1 cycle from the completing pixel.
- Push and pop rules:
  - Pop when out_valid && out_ready.
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Otherwise the byte is dropped and overflow <= 1, held until reset.
  - Coordinates, bit_cnt and edge_count continue regardless, so frame alignment is preserved.
- Output stability: while out_valid = 1 and out_ready = 0, out_data and out_last are held stable.
- frame_done = 1 for exactly one cycle following the edge at which the out_last byte is popped.
- All arithmetic is unsigned. The running count is 32-bit and does not saturate; the maximum is OUT_W*OUT_H.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with random inputs → out_valid = 0, out_last = 0, frame_done = 0, overflow = 0, edge_count = 0.
- All-edge frame (OUT_W=10, OUT_H=2), 20 pixels of 255, out_ready = 1:
  - bytes 0xFF, 0x03, 0xFF, 0x03; out_last only on the 4th.
  - frame_done pulses once; edge_count = 20.
- Pattern (OUT_W=8, OUT_H=1), pixels 255,0,255,0,255,0,255,0 → single byte 0x55 with out_last = 1; edge_count = 4.
- Backpressure (FIFO_DEPTH=4, OUT_W=8, OUT_H=6), out_ready = 0 for the whole input frame:
  - 4 bytes retained, overflow = 1.
  - After out_ready = 1, the first 4 bytes come out in order; no out_last appears (6th byte dropped).
  - edge_count is still correct.
- Gapped input: the all-edge test with pixel_valid_in toggled randomly (≥50% idle) → identical byte sequence and edge_count; each byte appears exactly 1 cycle after its completing pixel when the FIFO is empty.
- Reset mid-frame (after 7 pixels), then a full 0x55 frame → only that frame's bytes are emitted; edge_count reflects only the new frame.

Source files
------------

// File: rtl/sobel_edge_packer_if.sv
// Packed-byte output stream of the Sobel edge packer.
// Valid/ready handshake carrying one byte per beat plus an end-of-frame marker.
interface sobel_edge_packer_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/sobel_edge_packer.sv
// Packs the binary Sobel edge stream into LSB-first bytes, pads each row to a byte
// boundary, buffers bytes in a FWFT FIFO and keeps a per-frame edge-pixel count.
module sobel_edge_packer #(
   parameter int OUT_W      = 510,
   parameter int OUT_H      = 510,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             pixel_in,
   input  logic                   pixel_valid_in,
   sobel_edge_packer_if.master    o_byte,
   output logic [31:0]            edge_count,
   output logic                   frame_done,
   output logic                   overflow
);

   localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_H - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   // Pack and coordinate state
   logic [7:0]       r_pack;
   logic [2:0]       r_bit_cnt;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;
   logic [31:0]      r_run_cnt;
   logic [31:0]      r_edge_count;

   // FIFO state
   fifo_entry_t      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Status
   logic             r_overflow;
   logic             r_frame_done;

   logic             w_bit;
   logic [7:0]       w_pack_next;
   logic             w_col_end;
   logic             w_row_end;
   logic             w_byte_done;
   logic             w_frame_end;
   logic             w_valid;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   fifo_entry_t      w_head;

   assign w_bit       = pixel_in[7];
   assign w_pack_next = r_pack | ({7'd0, w_bit} << r_bit_cnt);
   assign w_col_end   = (r_col == LAST_COL);
   assign w_row_end   = (r_row == LAST_ROW);
   assign w_byte_done = pixel_valid_in && ((r_bit_cnt == 3'd7) || w_col_end);
   assign w_frame_end = pixel_valid_in && w_col_end && w_row_end;

   assign w_head  = r_mem[r_rd_ptr];
   assign w_valid = (r_count != '0);

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      w_pop  = 1'b0;
      w_push = 1'b0;
      w_drop = 1'b0;
      if (w_valid && o_byte.out_ready) begin
         w_pop = 1'b1;
      end
      if (w_byte_done) begin
         if ((r_count < FULL_CNT) || w_pop) begin
            w_push = 1'b1;
         end else begin
            w_drop = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pack       <= '0;
         r_bit_cnt    <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_run_cnt    <= '0;
         r_edge_count <= '0;
      end else if (pixel_valid_in) begin
         if (w_byte_done) begin
            r_pack    <= '0;
            r_bit_cnt <= '0;
         end else begin
            r_pack    <= w_pack_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end

         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
         end else begin
            r_col <= r_col + COL_W'(1);
         end

         if (w_frame_end) begin
            r_edge_count <= r_run_cnt + 32'(w_bit);
            r_run_cnt    <= '0;
         end else begin
            r_run_cnt    <= r_run_cnt + 32'(w_bit);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // NOTE: storage is not reset; entries are only observed once the count says they are valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{last: w_frame_end, data: w_pack_next};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         r_frame_done <= w_pop && w_head.last;
      end
   end

   // Head is gated so the outputs read zero whenever the FIFO is empty.
   assign o_byte.out_valid = w_valid;
   assign o_byte.out_data  = w_valid ? w_head.data : 8'd0;
   assign o_byte.out_last  = w_valid ? w_head.last : 1'b0;

   assign edge_count = r_edge_count;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;

endmodule
